// File: rtl/dmem_port_arbiter.sv
`timescale 1ns/1ps
// dmem_port_arbiter: shares one word-aligned data-memory port between fetch (IF) and
// load/store (LS). LS wins ties; a streak counter bounds how long IF can be held off.
module dmem_port_arbiter #(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [3:0]  ls_wmask,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int unsigned SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } busReq_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

  state_t        state, stateNext;
  logic [SW-1:0] streak, streakNext;
  busReq_t       bus, busNext, ifCand, lsCand;
  logic          memReqR, memReqNext;
  logic          ownerLs, ownerLsNext;
  logic [31:0]   ifRdataR, ifRdataNext, lsRdataR, lsRdataNext;
  logic          ifAckR, ifAckNext, lsAckR, lsAckNext;
  logic          streakFull, pickLs;
  logic          unusedAddrLsb;

  // Byte offsets never reach the bus; the requester does its own lane selection.
  assign unusedAddrLsb = ^{if_addr[1:0], ls_addr[1:0]};

  always_comb begin
    ifCand      = '0;
    ifCand.addr = {if_addr[31:2], 2'b00};
    lsCand      = '0;
    lsCand.we   = ls_we;
    lsCand.addr = {ls_addr[31:2], 2'b00};
    if (ls_we) begin
      lsCand.wmask = ls_wmask;
      lsCand.wdata = ls_wdata;
    end
  end

  assign streakFull = (streak == STREAK_MAX);
  assign pickLs     = ls_req & ~(if_req & streakFull);

  always_comb begin
    stateNext   = state;
    streakNext  = streak;
    busNext     = bus;
    memReqNext  = memReqR;
    ownerLsNext = ownerLs;
    ifRdataNext = ifRdataR;
    lsRdataNext = lsRdataR;
    ifAckNext   = 1'b0;
    lsAckNext   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!if_req) streakNext = '0;
        if (ls_req | if_req) begin
          stateNext   = BUSY;
          memReqNext  = 1'b1;
          ownerLsNext = pickLs;
          if (pickLs) begin
            busNext = lsCand;
            // Only LS wins taken against a waiting IF count toward the streak.
            if (if_req) streakNext = streakFull ? streak : streak + SW'(1);
          end else begin
            busNext    = ifCand;
            streakNext = '0;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          memReqNext = 1'b0;
          stateNext  = ACK;
          if (ownerLs) begin
            lsAckNext = 1'b1;
            if (!bus.we) lsRdataNext = mem_rdata;
          end else begin
            ifAckNext   = 1'b1;
            ifRdataNext = mem_rdata;
          end
        end
      end
      ACK:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      streak   <= '0;
      bus      <= '0;
      memReqR  <= 1'b0;
      ownerLs  <= 1'b0;
      ifRdataR <= '0;
      lsRdataR <= '0;
      ifAckR   <= 1'b0;
      lsAckR   <= 1'b0;
    end else begin
      state    <= stateNext;
      streak   <= streakNext;
      bus      <= busNext;
      memReqR  <= memReqNext;
      ownerLs  <= ownerLsNext;
      ifRdataR <= ifRdataNext;
      lsRdataR <= lsRdataNext;
      ifAckR   <= ifAckNext;
      lsAckR   <= lsAckNext;
    end
  end

  assign mem_req   = memReqR;
  assign mem_we    = bus.we;
  assign mem_addr  = bus.addr;
  assign mem_wmask = bus.wmask;
  assign mem_wdata = bus.wdata;
  assign if_rdata  = ifRdataR;
  assign ls_rdata  = lsRdataR;
  assign if_ack    = ifAckR;
  assign ls_ack    = lsAckR;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for dmem_port_arbiter: directed vector table, hand sequences for the multi-cycle
// corners, then randomized traffic against a transaction-level reference model.
module tb_dmem_port_arbiter;
  localparam int MAXS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, ifAck;
  logic [31:0] ifAddr, ifRdata;
  logic        lsReq, lsWe, lsAck;
  logic [31:0] lsAddr, lsWdata, lsRdata;
  logic [3:0]  lsWmask;
  logic        memReq, memWe, memReady;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memWmask;

  dmem_port_arbiter #(.MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ack(ifAck),
    .ls_req(lsReq), .ls_we(lsWe), .ls_addr(lsAddr), .ls_wmask(lsWmask),
    .ls_wdata(lsWdata), .ls_rdata(lsRdata), .ls_ack(lsAck),
    .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wmask(memWmask),
    .mem_wdata(memWdata), .mem_rdata(memRdata), .mem_ready(memReady)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    ifReq = 0; ifAddr = '0;
    lsReq = 0; lsWe = 0; lsAddr = '0; lsWmask = '0; lsWdata = '0;
    memReady = 0; memRdata = '0;
  endtask

  typedef struct {
    bit          isLs;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] expAddr;
    bit          expWe;
    logic [3:0]  expWmask;
    int          expAckCyc;
  } vec_t;

  vec_t vecs[7];

  // reference model: one outstanding access, ack one cycle after ready, then a free cycle
  bit          mBusy, mOwnerLs, mWe;
  int          mAckWho, mStreak;
  logic [31:0] mAddr, mWdata, mIfRd, mLsRd;
  logic [3:0]  mWmask;

  task automatic modelReset();
    mBusy = 0; mOwnerLs = 0; mWe = 0; mAckWho = 0; mStreak = 0;
    mAddr = '0; mWdata = '0; mIfRd = '0; mLsRd = '0; mWmask = '0;
  endtask

  task automatic modelStep();
    bit lsWins;
    if (mAckWho != 0) begin
      mAckWho = 0;
    end else if (mBusy) begin
      if (memReady) begin
        mBusy = 0;
        if (mOwnerLs) begin
          if (!mWe) mLsRd = memRdata;
          mAckWho = 2;
        end else begin
          mIfRd = memRdata;
          mAckWho = 1;
        end
      end
    end else begin
      if (!ifReq) mStreak = 0;
      if (lsReq || ifReq) begin
        lsWins = lsReq && !(ifReq && mStreak == MAXS);
        mBusy = 1;
        mOwnerLs = lsWins;
        if (lsWins) begin
          mWe = lsWe;
          mAddr = lsAddr & 32'hFFFF_FFFC;
          mWmask = lsWe ? lsWmask : 4'h0;
          mWdata = lsWdata;
          if (ifReq) mStreak = (mStreak + 1 > MAXS) ? MAXS : mStreak + 1;
        end else begin
          mWe = 0; mAddr = ifAddr & 32'hFFFF_FFFC; mWmask = 4'h0;
          mStreak = 0;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] expIfRd, expLsRd, lastRd;
    int lsAckC, ifAckC, both, nGrants;
    logic [5:0] grants;
    logic prevReq;

    vecs[0] = '{0, 0, 32'h0000_0104, 4'h0, 32'h0,         0, 32'h1122_3344, 32'h0000_0104, 0, 4'h0, 2};
    vecs[1] = '{1, 0, 32'h0000_1003, 4'h0, 32'h0,         0, 32'hCAFE_F00D, 32'h0000_1000, 0, 4'h0, 2};
    vecs[2] = '{1, 1, 32'h0000_2002, 4'h4, 32'hAAAA_AAAA, 1, 32'h1234_5678, 32'h0000_2000, 1, 4'h4, 3};
    vecs[3] = '{1, 1, 32'h0000_3001, 4'h0, 32'h5555_0000, 0, 32'h0BAD_0BAD, 32'h0000_3000, 1, 4'h0, 2};
    vecs[4] = '{0, 0, 32'hFFFF_FFFF, 4'h0, 32'h0,         2, 32'h5A5A_A5A5, 32'hFFFF_FFFC, 0, 4'h0, 4};
    vecs[5] = '{1, 0, 32'h8000_0006, 4'hF, 32'hFFFF_FFFF, 0, 32'h8765_4321, 32'h8000_0004, 0, 4'h0, 2};
    vecs[6] = '{1, 1, 32'h0000_0007, 4'hF, 32'hDEAD_BEEF, 3, 32'h0F0F_0F0F, 32'h0000_0004, 1, 4'hF, 5};

    driveIdle();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset mem_req", memReq, 0);
    chk("reset mem_we/wmask", {memWe, memWmask}, 0);
    chk("reset mem_addr", memAddr, 0);
    chk("reset mem_wdata", memWdata, 0);
    chk("reset acks", {ifAck, lsAck}, 0);
    chk("reset if_rdata", ifRdata, 0);
    chk("reset ls_rdata", lsRdata, 0);
    rst = 0;
    @(negedge clk);
    expIfRd = '0; expLsRd = '0;

    for (int v = 0; v < 7; v++) begin
      int ackCyc, acks, wrongAcks;
      ackCyc = -1; acks = 0; wrongAcks = 0;
      if (vecs[v].isLs) begin
        lsReq = 1; lsWe = vecs[v].we; lsAddr = vecs[v].addr;
        lsWmask = vecs[v].wmask; lsWdata = vecs[v].wdata;
      end else begin
        ifReq = 1; ifAddr = vecs[v].addr;
      end
      memReady = 0; memRdata = ~vecs[v].rdata;
      for (int c = 1; c <= vecs[v].waits + 4; c++) begin
        @(negedge clk);
        if (c <= vecs[v].waits + 1) begin
          chk($sformatf("v%0d c%0d mem_req", v, c), memReq, 1);
          chk($sformatf("v%0d c%0d mem_addr", v, c), memAddr, vecs[v].expAddr);
          chk($sformatf("v%0d c%0d we/wmask", v, c), {memWe, memWmask}, {vecs[v].expWe, vecs[v].expWmask});
          if (vecs[v].we) chk($sformatf("v%0d c%0d mem_wdata", v, c), memWdata, vecs[v].wdata);
        end
        if (c == vecs[v].waits + 2) chk($sformatf("v%0d mem_req drop", v), memReq, 0);
        if (ifAck || lsAck) begin
          acks++;
          if (ackCyc < 0) ackCyc = c;
        end
        if (vecs[v].isLs ? ifAck : lsAck) wrongAcks++;
        if (ackCyc == c) begin
          if (vecs[v].isLs) begin
            if (!vecs[v].we) expLsRd = vecs[v].rdata;
          end else expIfRd = vecs[v].rdata;
          chk($sformatf("v%0d if_rdata", v), ifRdata, expIfRd);
          chk($sformatf("v%0d ls_rdata", v), lsRdata, expLsRd);
          ifReq = 0; lsReq = 0;
        end
        memReady = (c >= vecs[v].waits + 1);
        memRdata = memReady ? vecs[v].rdata : ~vecs[v].rdata;
      end
      chk($sformatf("v%0d ack cycle", v), ackCyc, vecs[v].expAckCyc);
      chk($sformatf("v%0d ack count", v), acks, 1);
      chk($sformatf("v%0d wrong ack", v), wrongAcks, 0);
      driveIdle();
    end

    // both request at once: LS store first, IF in the following window
    @(negedge clk);
    ifReq = 1; ifAddr = 32'h400;
    lsReq = 1; lsWe = 1; lsAddr = 32'h2002; lsWmask = 4'b0100; lsWdata = 32'hAAAA_AAAA;
    memReady = 0; lsAckC = -1; ifAckC = -1; both = 0; lastRd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("tie c1 mem_we/addr", {31'(memAddr[31:1]), memWe}, {31'(32'h2000 >> 1), 1'b1});
        chk("tie c1 mem_wmask", memWmask, 4'b0100);
      end
      if (c == 4) chk("tie c4 IF bus", {memReq, memWe, memAddr}, {1'b1, 1'b0, 32'h400});
      if (ifAck && lsAck) both++;
      if (lsAck && lsAckC < 0) begin lsAckC = c; lsReq = 0; end
      if (ifAck && ifAckC < 0) begin
        ifAckC = c; ifReq = 0;
        chk("tie if_rdata", ifRdata, lastRd);
      end
      memReady = 1; memRdata = $urandom; lastRd = memRdata;
    end
    chk("tie ls_ack cycle", lsAckC, 2);
    chk("tie if_ack cycle", ifAckC, 5);
    chk("tie both acks", both, 0);
    driveIdle();

    // both held continuously: grant pattern follows the streak limit
    @(negedge clk);
    ifReq = 1; ifAddr = 32'h100; lsReq = 1; lsWe = 0; lsAddr = 32'h200; memReady = 1;
    grants = '0; nGrants = 0; both = 0; prevReq = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (memReq && !prevReq) begin
        nGrants++;
        grants = {grants[4:0], memAddr == 32'h200};
      end
      if (ifAck && lsAck) both++;
      prevReq = memReq;
      memRdata = $urandom;
    end
    chk("streak grant count", nGrants, 6);
    chk("streak grant order", grants, 6'b110110);
    chk("streak both acks", both, 0);
    driveIdle();

    // reset while BUSY drops the bus request at once, then arbitration restarts
    @(negedge clk);
    ifReq = 1; ifAddr = 32'h500; memReady = 0;
    repeat (2) @(negedge clk);
    chk("rstbusy precond mem_req", memReq, 1);
    #2 rst = 1;
    #1;
    chk("rstbusy mem_req", memReq, 0);
    chk("rstbusy acks", {ifAck, lsAck}, 0);
    chk("rstbusy mem_addr", memAddr, 0);
    chk("rstbusy if_rdata", ifRdata, 0);
    @(negedge clk);
    ifReq = 0; lsReq = 1; lsWe = 0; lsAddr = 32'h604; memReady = 1; memRdata = 32'h600D_600D;
    rst = 0;
    @(negedge clk);
    chk("rstbusy fresh bus", {memReq, memWe, memAddr}, {1'b1, 1'b0, 32'h604});
    @(negedge clk);
    chk("rstbusy fresh acks", {ifAck, lsAck}, 2'b01);
    chk("rstbusy fresh ls_rdata", lsRdata, 32'h600D_600D);
    driveIdle();

    // randomized traffic against the model
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    driveIdle();
    rst = 0;
    modelReset();
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      chk($sformatf("rnd t%0d mem_req", t), memReq, mBusy);
      if (mBusy) begin
        chk($sformatf("rnd t%0d mem_addr", t), memAddr, mAddr);
        chk($sformatf("rnd t%0d we/wmask", t), {memWe, memWmask}, {mWe, mWmask});
        if (mWe) chk($sformatf("rnd t%0d mem_wdata", t), memWdata, mWdata);
      end
      chk($sformatf("rnd t%0d acks", t), {ifAck, lsAck}, {mAckWho == 1, mAckWho == 2});
      if (mAckWho == 1) chk($sformatf("rnd t%0d if_rdata", t), ifRdata, mIfRd);
      if (mAckWho == 2) chk($sformatf("rnd t%0d ls_rdata", t), lsRdata, mLsRd);
      if (mAckWho == 1) ifReq = 0;
      else if (!ifReq && ($urandom % 3 == 0)) begin
        ifReq = 1; ifAddr = $urandom;
      end
      if (mAckWho == 2) lsReq = 0;
      else if (!lsReq && ($urandom % 2 == 0)) begin
        lsReq = 1; lsWe = $urandom % 2; lsAddr = $urandom;
        lsWmask = 4'($urandom); lsWdata = $urandom;
      end
      memReady = ($urandom % 3) != 0;
      memRdata = $urandom;
      modelStep();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
